// File: rtl/mips32_loader_pkg.sv
// Shared definitions for the mips32 boot-time program loader: FSM encoding,
// frame field widths and the default sync marker.
package mips32_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int TMO_W  = 16;
  localparam int LANE_W = 2;

  // Number of words that fit between the base address and the top of memory.
  function automatic int max_words(input int addr_w, input int base);
    return (1 << addr_w) - base;
  endfunction

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// The loader uses the slave view; the stream source / memory model uses master.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/loader_word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid pulses for one
// cycle after the fourth byte, and clr drops any partially packed word.
module loader_word_packer
  import mips32_loader_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [LANE_W-1:0] lane,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [LANE_W-1:0]        lane_reg;
  logic [WORD_W-BYTE_W-1:0] shift_reg;
  logic [WORD_W-1:0]        word_reg;
  logic                     valid_reg;
  logic                     last_lane;

  assign last_lane = &lane_reg;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg  <= '0;
      shift_reg <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (clr) begin
      lane_reg  <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= byte_en && last_lane;
      if (byte_en) begin
        lane_reg  <= lane_reg + LANE_W'(1);
        shift_reg <= {shift_reg[WORD_W-2*BYTE_W-1:0], byte_in};
        if (last_lane) begin
          word_reg <= {shift_reg, byte_in};
        end
      end
    end
  end

  assign lane       = lane_reg;
  assign word_valid = valid_reg;
  assign word_data  = word_reg;

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader: parses SYNC/LEN/payload/CSUM frames, writes the payload words
// into core memory from BASE_ADDR and releases the core once the checksum passes.
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         BASE_ADDR = 0,
  parameter int         TIMEOUT   = 65535,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                clk1,
  input  logic                rst_n,
  mips32_prog_loader_if.slave bus,
  output logic [ADDR_W:0]     words_loaded,
  output logic                core_run,
  output logic                load_err,
  output logic                busy
);

  localparam int                MAX_WORDS = max_words(ADDR_W, BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [BYTE_W-1:0]  csum_reg, csum_next;
  logic [ADDR_W:0]    wl_reg, wl_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;

  logic               accept;
  logic               is_sync;
  logic               in_frame;
  logic               pk_en;
  logic               pk_clr;
  logic [LANE_W-1:0]  pk_lane;
  logic               pk_valid;
  logic [WORD_W-1:0]  pk_word;
  logic [ADDR_W:0]    wl_inc;

  assign bus.in_ready = (state_reg != ST_DONE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_sync      = (bus.in_data == SYNC_BYTE);
  assign in_frame     = (state_reg == ST_LEN_HI) || (state_reg == ST_LEN_LO) ||
                        (state_reg == ST_DATA)   || (state_reg == ST_CSUM);
  assign wl_inc       = wl_reg + (ADDR_W+1)'(1);

  loader_word_packer u_packer (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .byte_en    (pk_en),
    .byte_in    (bus.in_data),
    .lane       (pk_lane),
    .word_valid (pk_valid),
    .word_data  (pk_word)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      csum_reg  <= '0;
      wl_reg    <= '0;
      addr_reg  <= BASE;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      csum_reg  <= csum_next;
      wl_reg    <= wl_next;
      addr_reg  <= addr_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    csum_next  = csum_reg;
    wl_next    = wl_reg;
    addr_next  = addr_reg;
    tmo_next   = '0;
    pk_en      = 1'b0;
    pk_clr     = 1'b0;

    case (state_reg)
      ST_IDLE, ST_ERROR: begin
        if (accept && is_sync) begin
          state_next = ST_LEN_HI;
          csum_next  = '0;
          wl_next    = '0;
          pk_clr     = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_next   = {bus.in_data, len_reg[BYTE_W-1:0]};
          csum_next  = csum_reg ^ bus.in_data;
          state_next = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_next  = {len_reg[LEN_W-1:BYTE_W], bus.in_data};
          csum_next = csum_reg ^ bus.in_data;
          if (len_next == '0) begin
            state_next = ST_CSUM;
          end else if (32'(len_next) > 32'(MAX_WORDS)) begin
            state_next = ST_ERROR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          pk_en     = 1'b1;
          csum_next = csum_reg ^ bus.in_data;
          if (&pk_lane) begin
            // Address latched with the pre-increment count, alongside the packer's word.
            addr_next = BASE + wl_reg[ADDR_W-1:0];
            wl_next   = wl_inc;
            if (32'(wl_inc) == 32'(len_reg)) begin
              state_next = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_next = (bus.in_data == csum_reg) ? ST_DONE : ST_ERROR;
        end
      end
      default: ;
    endcase

    if (in_frame && !accept && (TIMEOUT != 0)) begin
      if (32'(tmo_reg) == 32'(TIMEOUT - 1)) begin
        state_next = ST_ERROR;
        pk_clr     = 1'b1;
      end else begin
        tmo_next = tmo_reg + TMO_W'(1);
      end
    end
  end

  assign bus.mem_we    = pk_valid;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = pk_word;
  assign words_loaded  = wl_reg;
  assign core_run      = (state_reg == ST_DONE);
  assign load_err      = (state_reg == ST_ERROR);
  assign busy          = in_frame;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: table-driven frames plus hand
// sequences for throughput, timeout and asynchronous reset, with a write scoreboard.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 10;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    string       name;
    bit          rst;
    int          nb;
    logic [95:0] bytes;
    int          nw;
    logic [31:0] w0;
    int          wl;
    bit          run;
    bit          err;
  } vec_t;

  logic clk1;
  logic rst_n;
  logic [ADDR_W:0] words_loaded;
  logic core_run;
  logic load_err;
  logic busy;

  int n_checks;
  int n_fail;
  wr_t exp_q[$];
  vec_t vec[5];

  mips32_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips32_prog_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0),
    .TIMEOUT   (16),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .bus          (bus),
    .words_loaded (words_loaded),
    .core_run     (core_run),
    .load_err     (load_err),
    .busy         (busy)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Write scoreboard: every mem_we must match the oldest expected write.
  always @(negedge clk1) begin
    if (rst_n && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("write addr=%0d data=%08h", bus.mem_addr, bus.mem_wdata);
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk1);
      n++;
    end
    check("ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk1);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_mem_we"},   32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"},    bus.mem_wdata, 32'd0);
    check({tag, "_wl"},       32'(words_loaded), 32'd0);
    check({tag, "_run"},      32'(core_run), 32'd0);
    check({tag, "_err"},      32'(load_err), 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  // Three-word frame; checksum and expected writes derived here from the words.
  task automatic send_words3(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input bit gaps);
    logic [31:0] w[3];
    logic [7:0]  cs;
    logic [7:0]  b;
    w[0] = w0; w[1] = w1; w[2] = w2;
    cs = 8'h00 ^ 8'h03;
    for (int k = 0; k < 3; k++) push_wr(k, w[k]);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h03);
    for (int k = 0; k < 12; k++) begin
      b = w[k/4][31-8*(k%4) -: 8];
      cs = cs ^ b;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk1);
      send_byte(b);
    end
    send_byte(cs);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;

    vec[0] = '{"single",   1'b0, 8, {64'hA500011234567809, 32'h0}, 1, 32'h12345678, 1, 1'b1, 1'b0};
    vec[1] = '{"bad_csum", 1'b1, 8, {64'hA50001123456780A, 32'h0}, 1, 32'h12345678, 1, 1'b0, 1'b1};
    vec[2] = '{"recover",  1'b0, 8, {64'hA50001CAFEBABE31, 32'h0}, 1, 32'hCAFEBABE, 1, 1'b1, 1'b0};
    vec[3] = '{"oversize", 1'b1, 3, {24'hA50401, 72'h0},           0, 32'h0,        0, 1'b0, 1'b1};
    vec[4] = '{"zero_len", 1'b1, 6, {48'h00FFA5000000, 48'h0},     0, 32'h0,        0, 1'b1, 1'b0};

    for (int i = 0; i < 5; i++) begin
      if (vec[i].rst) do_reset();
      if (vec[i].nw == 1) push_wr(0, vec[i].w0);
      for (int k = 0; k < vec[i].nb; k++) send_byte(vec[i].bytes[95-8*k -: 8]);
      $display("frame %s: wl=%0d run=%0b err=%0b busy=%0b",
               vec[i].name, words_loaded, core_run, load_err, busy);
      check({vec[i].name, "_wl"},   32'(words_loaded), 32'(vec[i].wl));
      check({vec[i].name, "_run"},  32'(core_run), 32'(vec[i].run));
      check({vec[i].name, "_err"},  32'(load_err), 32'(vec[i].err));
      check({vec[i].name, "_busy"}, 32'(busy), 32'd0);
      check({vec[i].name, "_writes_done"}, 32'(exp_q.size()), 32'd0);
    end

    // DONE ignores the stream.
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (5) @(negedge clk1);
    bus.in_valid = 1'b0;
    $display("done_hold: run=%0b busy=%0b wl=%0d", core_run, busy, words_loaded);
    check("done_hold_run",  32'(core_run), 32'd1);
    check("done_hold_busy", 32'(busy), 32'd0);

    // Throughput: back-to-back, then random gaps.
    do_reset();
    send_words3(32'h01020304, 32'hDEADBEEF, 32'h89ABCDEF, 1'b0);
    $display("burst3: wl=%0d run=%0b", words_loaded, core_run);
    check("burst_wl",  32'(words_loaded), 32'd3);
    check("burst_run", 32'(core_run), 32'd1);
    do_reset();
    send_words3(32'h01020304, 32'hDEADBEEF, 32'h89ABCDEF, 1'b1);
    $display("gappy3: wl=%0d run=%0b", words_loaded, core_run);
    check("gappy_wl",  32'(words_loaded), 32'd3);
    check("gappy_run", 32'(core_run), 32'd1);
    check("gappy_writes_done", 32'(exp_q.size()), 32'd0);

    // Timeout: 16 idle cycles mid-DATA with a partial second word.
    do_reset();
    push_wr(0, 32'h11223344);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    repeat (15) @(posedge clk1);
    #1;
    check("tmo_15_busy", 32'(busy), 32'd1);
    @(posedge clk1);
    #1;
    $display("timeout: err=%0b busy=%0b run=%0b", load_err, busy, core_run);
    check("tmo_16_err",  32'(load_err), 32'd1);
    check("tmo_16_busy", 32'(busy), 32'd0);
    check("tmo_16_run",  32'(core_run), 32'd0);
    repeat (4) @(negedge clk1);
    push_wr(0, 32'hAABBCCDD);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h01);
    check("tmo_recover_run", 32'(core_run), 32'd1);
    check("tmo_recover_err", 32'(load_err), 32'd0);

    // Asynchronous reset mid-DATA.
    do_reset();
    push_wr(0, 32'h11223344);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_wl",   32'(words_loaded), 32'd1);
    rst_n = 1'b0;
    #1;
    $display("async_reset: busy=%0b wl=%0d we=%0b", busy, words_loaded, bus.mem_we);
    check_reset_outputs("mid_rst");
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk1);
    check("final_writes_done", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
